number_capture: RTL and testbench
=================================

Name: number_capture

Overview:
- Reader at the far end of the free-running 0..100 game counter.
- Debounces a player button and samples the counter value at the instant of a confirmed press.
- Compares the sample against a target value and reports the hit/miss result, the absolute error and a running score.
- Output feeds the display/scoring logic. Only one sample is taken per press; the button must be released before it re-arms.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a press or release (10 ms at 50 MHz).
- TOLERANCE, 0, maximum absolute difference still counted as a hit.
- NUM_MAX, 100, highest legal counter value.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- current_number  input  7  live counter value, 0..NUM_MAX.
- capture_btn  input  1  raw asynchronous button, active-high.
- target  input  7  value the player is aiming for; sampled together with current_number.
- captured  output  7  counter value latched at the last accepted press.
- diff  output  7  absolute value of (captured - target_latched).
- hit  output  1  high when diff <= TOLERANCE and the sample is legal.
- invalid  output  1  high when the latched sample or target > NUM_MAX.
- result_valid  output  1  one-cycle pulse when captured/diff/hit/invalid update.
- score  output  8  count of hits since reset, saturating at 255.
- armed  output  1  high while the block is waiting for a press.

Behaviour:
- Reset: all outputs 0 except armed = 1. Synchronizer flops and the debounce counter are cleared, and the FSM goes to ARMED. Reset has priority in every state; an in-progress debounce is discarded.
- Synchronizer: capture_btn passes through 2 flops, giving btn_s. Only btn_s is used downstream.
- FSM states: ARMED, PRESS_WAIT, CAPTURE, RELEASE_WAIT.
- ARMED: debounce counter = 0; armed = 1. If btn_s = 1, go to PRESS_WAIT with counter = 1.
- PRESS_WAIT:
  - btn_s = 0: return to ARMED, counter cleared (glitch rejected).
  - btn_s = 1 and counter = DEBOUNCE_CYCLES-1: go to CAPTURE.
  - Otherwise increment the counter.
- CAPTURE: lasts exactly one cycle.
  - At this clock edge, captured <= current_number and target_latched <= target.
  - Next state is RELEASE_WAIT.
- Result cycle: on the cycle after CAPTURE, result_valid = 1 and diff, hit, invalid and score already reflect the new sample. Total latency from the first stable btn_s high is DEBOUNCE_CYCLES + 2 cycles.
- diff: computed as the larger value minus the smaller in 7 bits, so it never wraps (0 vs 100 gives 100).
- invalid: if captured > NUM_MAX or target_latched > NUM_MAX, then invalid = 1, hit = 0 and score is unchanged.
- score: increments by 1 on the result cycle when hit = 1. At 255 it holds at 255.
- RELEASE_WAIT:
  - armed = 0.
  - Requires DEBOUNCE_CYCLES consecutive btn_s = 0 samples, then goes to ARMED.
  - Any btn_s = 1 restarts the count.
  - No new capture is possible here, so holding the button produces exactly one result.
- Counter wrap: a current_number transition from 100 to 0 on the capture edge is sampled as-is. No special case applies; whichever value is present at the edge is taken.
- Output hold: captured, diff, hit and invalid hold their values until the next result cycle. armed is 1 only in ARMED and PRESS_WAIT.

Decomposition:
- Package number_capture_pkg:
  - state enum {ARMED, PRESS_WAIT, CAPTURE, RELEASE_WAIT};
  - NUM_W = 7, SCORE_W = 8, NUM_MAX = 100.
- Sub-module btn_debouncer:
  - contains the 2-flop synchronizer and the stable-level counter;
  - outputs a debounced level plus rise and fall strobes.
- number_capture keeps the FSM, latches, comparator and score.

Test Plan (bench uses DEBOUNCE_CYCLES = 4, TOLERANCE = 0 unless noted):
- Exact hit: target = 42; button held high while current_number = 42 at CAPTURE -> result_valid pulses once; captured = 42, diff = 0, hit = 1, score = 1, latency = 6 cycles from btn_s rising.
- Miss with tolerance: TOLERANCE = 2, target = 50; samples 48 and 53 on two separate presses -> first gives diff = 2, hit = 1; second gives diff = 3, hit = 0; score = 1.
- Glitch rejection: button high for 3 cycles then low -> no result_valid; armed stays 1; score unchanged.
- Held button: button held for 1000 cycles -> exactly one result_valid; armed = 0 until 4 stable low cycles after release.
- Boundary and illegal values:
  - target = 0, captured = 100 -> diff = 100, hit = 0;
  - target = 120 -> invalid = 1, hit = 0, score unchanged;
  - 256 forced hits -> score saturates at 255.
- Reset mid-operation: reset asserted in PRESS_WAIT counter = 3 -> next cycle armed = 1, no result_valid, outputs 0, and a subsequent press behaves normally.

Source files
------------

// File: rtl/number_capture_pkg.sv
// ============================================================================
// Module   : number_capture_pkg
// Brief    : Shared types and sizing for the number capture reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package number_capture_pkg;

    localparam int unsigned NUM_W   = 7;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned NUM_MAX = 100;

    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        PRESS_WAIT   = 2'd1,
        CAPTURE      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debouncer.sv
// ============================================================================
// Module   : btn_debouncer
// Brief    : Two-flop synchronizer plus stable-level filter for a raw button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debouncer #(
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_sync,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned c_cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               w_btn_s;
    logic               w_change;
    logic               w_done;

    assign w_btn_s  = r_sync[1];
    assign w_change = (w_btn_s != r_level);
    // Strobes are combinational so they coincide with the edge that flips the level.
    assign w_done   = w_change && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (!w_change) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_level <= w_btn_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync  = w_btn_s;
    assign o_level = r_level;
    assign o_rise  = w_done && w_btn_s;
    assign o_fall  = w_done && !w_btn_s;

endmodule

`default_nettype wire

// File: rtl/number_capture.sv
// ============================================================================
// Module   : number_capture
// Brief    : Samples the game counter on a debounced press and scores it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module number_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TOLERANCE       = 0,
    parameter int unsigned NUM_MAX         = number_capture_pkg::NUM_MAX
) (
    input  logic                                  CLOCK_50,
    input  logic                                  reset,
    input  logic [number_capture_pkg::NUM_W-1:0]  current_number,
    input  logic                                  capture_btn,
    input  logic [number_capture_pkg::NUM_W-1:0]  target,
    output logic [number_capture_pkg::NUM_W-1:0]  captured,
    output logic [number_capture_pkg::NUM_W-1:0]  diff,
    output logic                                  hit,
    output logic                                  invalid,
    output logic                                  result_valid,
    output logic [number_capture_pkg::SCORE_W-1:0] score,
    output logic                                  armed
);

    import number_capture_pkg::*;

    localparam logic [NUM_W-1:0] c_tol     = NUM_W'(TOLERANCE);
    localparam logic [NUM_W-1:0] c_num_max = NUM_W'(NUM_MAX);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_btn_s;
    logic                w_level;
    logic                w_rise;
    logic                w_fall;
    logic [NUM_W-1:0]    w_diff;
    logic                w_invalid;
    logic                w_hit;
    logic [NUM_W-1:0]    r_captured;
    logic [NUM_W-1:0]    r_diff;
    logic                r_hit;
    logic                r_invalid;
    logic                r_result_valid;
    logic [SCORE_W-1:0]  r_score;

    btn_debouncer #(
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_btn   (capture_btn),
        .o_sync  (w_btn_s),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARMED: begin
                if (w_rise) begin
                    w_state_next = CAPTURE;
                end else if (w_btn_s && !w_level) begin
                    w_state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_next = ARMED;
                end else if (w_rise) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (w_fall) begin
                    w_state_next = ARMED;
                end
            end
            default: begin
                w_state_next = ARMED;
            end
        endcase
    end

    // Larger minus smaller keeps the distance inside 7 bits without wrap.
    assign w_diff    = (current_number >= target) ? (current_number - target)
                                                  : (target - current_number);
    assign w_invalid = (current_number > c_num_max) || (target > c_num_max);
    assign w_hit     = !w_invalid && (w_diff <= c_tol);

    // Results are resolved at the capture edge so the following cycle sees them.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_captured     <= '0;
            r_diff         <= '0;
            r_hit          <= 1'b0;
            r_invalid      <= 1'b0;
            r_result_valid <= 1'b0;
            r_score        <= '0;
        end else begin
            r_result_valid <= (r_state == CAPTURE);
            if (r_state == CAPTURE) begin
                r_captured <= current_number;
                r_diff     <= w_diff;
                r_hit      <= w_hit;
                r_invalid  <= w_invalid;
                if (w_hit && (r_score != '1)) begin
                    r_score <= r_score + 1'b1;
                end
            end
        end
    end

    assign captured     = r_captured;
    assign diff         = r_diff;
    assign hit          = r_hit;
    assign invalid      = r_invalid;
    assign result_valid = r_result_valid;
    assign score        = r_score;
    assign armed        = (r_state == ARMED) || (r_state == PRESS_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_number_capture.sv
// ============================================================================
// Module   : tb_number_capture
// Brief    : Directed vector bench for number_capture (two tolerance settings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_number_capture;

    localparam int DEB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [6:0] current_number;
    logic       capture_btn;
    logic [6:0] target;

    logic [6:0] captured,  captured_t;
    logic [6:0] diff,      diff_t;
    logic       hit,       hit_t;
    logic       invalid,   invalid_t;
    logic       result_valid, result_valid_t;
    logic [7:0] score,     score_t;
    logic       armed,     armed_t;

    always #5 CLOCK_50 = ~CLOCK_50;

    number_capture #(.DEBOUNCE_CYCLES(DEB), .TOLERANCE(0), .NUM_MAX(100)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .current_number(current_number),
        .capture_btn(capture_btn), .target(target), .captured(captured),
        .diff(diff), .hit(hit), .invalid(invalid), .result_valid(result_valid),
        .score(score), .armed(armed)
    );

    number_capture #(.DEBOUNCE_CYCLES(DEB), .TOLERANCE(2), .NUM_MAX(100)) dut_t (
        .CLOCK_50(CLOCK_50), .reset(reset), .current_number(current_number),
        .capture_btn(capture_btn), .target(target), .captured(captured_t),
        .diff(diff_t), .hit(hit_t), .invalid(invalid_t), .result_valid(result_valid_t),
        .score(score_t), .armed(armed_t)
    );

    typedef struct {
        logic [6:0] tgt;
        logic [6:0] num;
        logic [6:0] exp_diff;
        logic       exp_hit0;
        logic       exp_hit2;
        logic       exp_inv;
    } vec_t;

    vec_t vecs[10];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_score0 = 0;
    int   exp_score2 = 0;
    int   p_pulses, p_lat, p_rel, p_armed_bad;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Press, hold for 'hold' cycles, release, then wait (bounded) for re-arm.
    task automatic do_press(input logic [6:0] tgt, input logic [6:0] num, input int hold);
        @(negedge CLOCK_50);
        target = tgt;
        current_number = num;
        capture_btn = 1'b1;
        p_pulses = 0; p_lat = -1; p_rel = -1; p_armed_bad = 0;
        for (int i = 1; i <= hold; i++) begin
            @(posedge CLOCK_50); #1;
            if (result_valid) begin
                p_pulses++;
                if (p_lat < 0) p_lat = i;
            end else if (p_lat >= 0 && armed) begin
                p_armed_bad++;
            end
        end
        capture_btn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLOCK_50); #1;
            if (result_valid) p_pulses++;
            if (armed) begin
                p_rel = i;
                break;
            end
        end
    endtask

    function automatic int sat_inc(input int s);
        return (s >= 255) ? 255 : s + 1;
    endfunction

    initial begin
        int rv_cnt, armed_lo;

        vecs[0] = '{7'd42,  7'd42,  7'd0,   1'b1, 1'b1, 1'b0};
        vecs[1] = '{7'd50,  7'd48,  7'd2,   1'b0, 1'b1, 1'b0};
        vecs[2] = '{7'd50,  7'd53,  7'd3,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{7'd0,   7'd100, 7'd100, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{7'd100, 7'd0,   7'd100, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{7'd120, 7'd50,  7'd70,  1'b0, 1'b0, 1'b1};
        vecs[6] = '{7'd50,  7'd101, 7'd51,  1'b0, 1'b0, 1'b1};
        vecs[7] = '{7'd100, 7'd100, 7'd0,   1'b1, 1'b1, 1'b0};
        vecs[8] = '{7'd127, 7'd127, 7'd0,   1'b0, 1'b0, 1'b1};
        vecs[9] = '{7'd7,   7'd9,   7'd2,   1'b0, 1'b1, 1'b0};

        reset = 1'b1; capture_btn = 1'b0; current_number = '0; target = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("reset_armed", armed, 1);
        check("reset_rv", result_valid, 0);
        check("reset_captured", captured, 0);
        check("reset_score", score, 0);
        check("reset_hit_inv", {hit, invalid}, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            do_press(vecs[v].tgt, vecs[v].num, 12);
            if (vecs[v].exp_hit0) exp_score0 = sat_inc(exp_score0);
            if (vecs[v].exp_hit2) exp_score2 = sat_inc(exp_score2);
            check($sformatf("v%0d_pulses", v), p_pulses, 1);
            // Raw press -> btn_s takes one synchronizer edge, then DEB+2 cycles.
            check($sformatf("v%0d_latency", v), p_lat, DEB + 3);
            check($sformatf("v%0d_captured", v), captured, vecs[v].num);
            check($sformatf("v%0d_diff", v), diff, vecs[v].exp_diff);
            check($sformatf("v%0d_hit", v), hit, vecs[v].exp_hit0);
            check($sformatf("v%0d_invalid", v), invalid, vecs[v].exp_inv);
            check($sformatf("v%0d_score", v), score, exp_score0);
            check($sformatf("v%0d_hit_tol2", v), hit_t, vecs[v].exp_hit2);
            check($sformatf("v%0d_score_tol2", v), score_t, exp_score2);
            check($sformatf("v%0d_rearm", v), p_rel, DEB + 2);
        end

        // Glitch: three cycles high is one short of acceptance.
        @(negedge CLOCK_50);
        target = 7'd10; current_number = 7'd10; capture_btn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        capture_btn = 1'b0;
        rv_cnt = 0; armed_lo = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLOCK_50); #1;
            if (result_valid) rv_cnt++;
            if (!armed) armed_lo++;
        end
        check("glitch_rv", rv_cnt, 0);
        check("glitch_armed_low", armed_lo, 0);
        check("glitch_score", score, exp_score0);

        // Long hold yields a single result and stays disarmed until release.
        do_press(7'd60, 7'd60, 1000);
        exp_score0 = sat_inc(exp_score0);
        exp_score2 = sat_inc(exp_score2);
        check("held_pulses", p_pulses, 1);
        check("held_armed_during_hold", p_armed_bad, 0);
        check("held_rearm", p_rel, DEB + 2);
        check("held_score", score, exp_score0);

        for (int k = 0; k < 256; k++) begin
            do_press(7'd5, 7'd5, 8);
            exp_score0 = sat_inc(exp_score0);
        end
        check("sat_score", score, 255);
        check("sat_model", score, exp_score0);

        // Reset while PRESS_WAIT holds count 3.
        @(negedge CLOCK_50);
        target = 7'd42; current_number = 7'd42; capture_btn = 1'b1;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1; capture_btn = 1'b0;
        @(posedge CLOCK_50); #1;
        check("rst_mid_armed", armed, 1);
        check("rst_mid_rv", result_valid, 0);
        check("rst_mid_score", score, 0);
        check("rst_mid_outs", {captured, diff, hit, invalid}, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50); #1;
            if (result_valid) rv_cnt++;
        end
        check("rst_mid_no_result", rv_cnt, 0);
        do_press(7'd42, 7'd42, 12);
        check("post_rst_pulses", p_pulses, 1);
        check("post_rst_captured", captured, 42);
        check("post_rst_hit", hit, 1);
        check("post_rst_score", score, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
